// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// Registered, width-generic ALU. It sits between an operand-issue stage and a
// writeback stage, and takes operands and returns results over a valid/ready
// handshake. Results and the C/Z/S/P flags are held in output registers until
// the consumer takes them. Every opcode except MUL completes in one cycle. MUL
// is an optional multi-cycle shift-add multiplier that handles one multiplier
// bit per cycle.
//
// Build option:
//   ALU_MUL_EN  defined   -> opcode 4'b1101 is the WIDTH-cycle multiply.
//               undefined -> no multiply datapath or state is built. Opcode
//                            4'b1101 completes in one cycle with Su=0 and
//                            op_err=1. busy is tied low.
//
// Parameters:
//   WIDTH      operand/result width, 4..32
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode presented
//   in_ready   block accepts operands this cycle
//   A, B       unsigned operands
//   SL         4-bit opcode
//   out_valid  result registers hold an undelivered result
//   out_ready  consumer takes the result this cycle
//   Su         result
//   C          carry / borrow / shifted-out bit
//   Z, S, P    zero, sign (MSB), odd parity of Su
//   busy       multiply in progress
//   op_err     opcode not supported in this build
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       SL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Su,
    output logic             C,
    output logic             Z,
    output logic             S,
    output logic             P,
    output logic             busy,
    output logic             op_err
);

    if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
        $error("seq_alu: WIDTH must be in 4..32");
    end

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_INC  = 4'b0010, OP_DEC  = 4'b0011,
        OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_XOR  = 4'b0110, OP_NOT  = 4'b0111,
        OP_SHL  = 4'b1000, OP_SHR  = 4'b1001, OP_ROL  = 4'b1010, OP_ROR  = 4'b1011,
        OP_SLT  = 4'b1100, OP_MUL  = 4'b1101, OP_PASS = 4'b1110, OP_CLR  = 4'b1111
    } opcode_e;

    opcode_e op;
    assign op = opcode_e'(SL);

    // ---------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] su_q, su_d;
    logic             c_q, c_d, z_q, z_d, s_q, s_d, p_q, p_d;
    logic             op_err_q, op_err_d;
    logic             out_valid_q, out_valid_d;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] a_shift_q, a_shift_d;
    logic [WIDTH-1:0]   b_shift_q, b_shift_d;
    logic [2*WIDTH-1:0] acc_sum;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign busy     = (state_q == ST_MUL);
`else
    // With no multi-cycle op the block is permanently idle.
    assign in_ready = !out_valid_q || out_ready;
    assign busy     = 1'b0;
`endif

    logic accept;
    assign accept = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // Single-cycle ALU
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_err;
    logic [WIDTH:0]   ext;   // one extra bit catches carry/borrow

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves it unassigned; otherwise synthesis infers a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        ext     = '0;
        case (op)
            OP_ADD: begin
                ext     = {1'b0, A} + {1'b0, B};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                ext     = {1'b0, A} - {1'b0, B};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];   // wraps to 1 exactly when A < B
            end
            OP_INC: begin
                ext     = {1'b0, A} + (WIDTH+1)'(1);
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_DEC: begin
                ext     = {1'b0, A} - (WIDTH+1)'(1);
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOT:  alu_res = ~A;
            OP_SHL: begin
                alu_res = {A[WIDTH-2:0], 1'b0};
                alu_c   = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, A[WIDTH-1:1]};
                alu_c   = A[0];
            end
            OP_ROL: begin
                alu_res = {A[WIDTH-2:0], A[WIDTH-1]};
                alu_c   = A[WIDTH-1];
            end
            OP_ROR: begin
                alu_res = {A[0], A[WIDTH-1:1]};
                alu_c   = A[0];
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res = '0;      // handled by the multi-cycle path
`else
            OP_MUL:  alu_err = 1'b1;
`endif
            OP_PASS: alu_res = B;
            OP_CLR:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    logic             load;
    logic [WIDTH-1:0] ld_res;
    logic             ld_c;
    logic             ld_err;

    always_comb begin
        su_d        = su_q;
        c_d         = c_q;
        z_d         = z_q;
        s_d         = s_q;
        p_d         = p_q;
        op_err_d    = op_err_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        ld_res      = '0;
        ld_c        = 1'b0;
        ld_err      = 1'b0;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_shift_d   = a_shift_q;
        b_shift_d   = b_shift_q;
        acc_sum     = acc_q + (b_shift_q[0] ? a_shift_q : '0);
`endif

        // The consumer drains the result; a load below overrides this.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
                state_d   = ST_MUL;
                cnt_d     = '0;
                acc_d     = '0;
                a_shift_d = {{WIDTH{1'b0}}, A};
                b_shift_d = B;
            end else begin
                load   = 1'b1;
                ld_res = alu_res;
                ld_c   = alu_c;
                ld_err = alu_err;
            end
`else
            load   = 1'b1;
            ld_res = alu_res;
            ld_c   = alu_c;
            ld_err = alu_err;
`endif
        end

`ifdef ALU_MUL_EN
        if (state_q == ST_MUL) begin
            acc_d     = acc_sum;
            a_shift_d = a_shift_q << 1;
            b_shift_d = b_shift_q >> 1;
            cnt_d     = cnt_q + CNT_W'(1);
            // The last bit's partial product is folded in on this edge, so
            // the result comes from acc_sum rather than from acc_q.
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                load    = 1'b1;
                ld_res  = acc_sum[WIDTH-1:0];
                ld_c    = |acc_sum[2*WIDTH-1:WIDTH];
                ld_err  = 1'b0;
            end
        end
`endif

        if (load) begin
            su_d        = ld_res;
            c_d         = ld_c;
            z_d         = ~|ld_res;
            s_d         = ld_res[WIDTH-1];
            p_d         = ^ld_res;
            op_err_d    = ld_err;
            out_valid_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            su_q        <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            p_q         <= 1'b0;
            op_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_shift_q   <= '0;
            b_shift_q   <= '0;
`endif
        end else begin
            su_q        <= su_d;
            c_q         <= c_d;
            z_q         <= z_d;
            s_q         <= s_d;
            p_q         <= p_d;
            op_err_q    <= op_err_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            a_shift_q   <= a_shift_d;
            b_shift_q   <= b_shift_d;
`endif
        end
    end

    assign Su        = su_q;
    assign C         = c_q;
    assign Z         = z_q;
    assign S         = s_q;
    assign P         = p_q;
    assign op_err    = op_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//
// Directed testbench for seq_alu at WIDTH=8. The stimulus process issues
// operations and pushes the hand-computed result of each one into a
// scoreboard queue. A separate monitor pops one entry on every delivery
// (out_valid && out_ready) and compares Su, C, Z, S, P and op_err. Handshake,
// busy and reset behaviour are checked directly by the stimulus process.
// Works with or without ALU_MUL_EN.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB = 4'b0001, OP_INC = 4'b0010,
                           OP_DEC  = 4'b0011, OP_AND = 4'b0100, OP_OR  = 4'b0101,
                           OP_XOR  = 4'b0110, OP_NOT = 4'b0111, OP_SHL = 4'b1000,
                           OP_SHR  = 4'b1001, OP_ROL = 4'b1010, OP_ROR = 4'b1011,
                           OP_SLT  = 4'b1100, OP_MUL = 4'b1101, OP_PASS = 4'b1110,
                           OP_CLR  = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [3:0]   SL;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Su;
    logic         C, Z, S, P, busy, op_err;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .SL        (SL),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Su        (Su),
        .C         (C),
        .Z         (Z),
        .S         (S),
        .P         (P),
        .busy      (busy),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] su;
        logic         c;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per delivery.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'(Su), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_Su"},     32'(Su),     32'(e.su));
                    check({e.name, "_C"},      32'(C),      32'(e.c));
                    check({e.name, "_ZSP"},    32'({Z, S, P}),
                          32'({~|e.su, e.su[W-1], ^e.su}));
                    check({e.name, "_op_err"}, 32'(op_err), 32'(e.err));
                end
            end
        end
    end

    // Present an op and wait (bounded) for it to be accepted. Returns 1ns
    // after the accept edge with in_valid still high, so consecutive calls
    // issue back-to-back.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] esu, input logic ec,
                         input logic eerr, input bit push);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        SL = op;
        A  = a;
        B  = b;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
        end else if (push) begin
            e.name = name;
            e.su   = esu;
            e.c    = ec;
            e.err  = eerr;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_Su"},        32'(Su),        32'd0);
        check({name, "_CZSP"},      32'({C, Z, S, P}), 32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
        check({name, "_op_err"},    32'(op_err),    32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        SL        = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---- back-to-back single-cycle ops, out_ready held high ----
        out_ready = 1'b1;
        stalls    = 0;
        issue("add",   OP_ADD,  8'h93, 8'h02, 8'h95, 1'b0, 1'b0, 1'b1);
        issue("sub",   OP_SUB,  8'h93, 8'h02, 8'h91, 1'b0, 1'b0, 1'b1);
        issue("shl",   OP_SHL,  8'h93, 8'h02, 8'h26, 1'b1, 1'b0, 1'b1);
        issue("ror",   OP_ROR,  8'h93, 8'h02, 8'hC9, 1'b1, 1'b0, 1'b1);
        issue("slt",   OP_SLT,  8'h93, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
        issue("inc",   OP_INC,  8'hFF, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1);
        issue("dec",   OP_DEC,  8'h00, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b1);
        issue("and",   OP_AND,  8'h93, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
        issue("or",    OP_OR,   8'h93, 8'h02, 8'h93, 1'b0, 1'b0, 1'b1);
        issue("xor",   OP_XOR,  8'h93, 8'h02, 8'h91, 1'b0, 1'b0, 1'b1);
        issue("not",   OP_NOT,  8'h93, 8'h02, 8'h6C, 1'b0, 1'b0, 1'b1);
        issue("shr",   OP_SHR,  8'h93, 8'h02, 8'h49, 1'b1, 1'b0, 1'b1);
        issue("rol",   OP_ROL,  8'h93, 8'h02, 8'h27, 1'b1, 1'b0, 1'b1);
        issue("pass",  OP_PASS, 8'h93, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
        issue("clr",   OP_CLR,  8'h93, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
        issue("sub_bw",OP_SUB,  8'h02, 8'h93, 8'h6F, 1'b1, 1'b0, 1'b1);
        issue("add_cy",OP_ADD,  8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b1);
        issue("slt_t", OP_SLT,  8'h02, 8'h93, 8'h01, 1'b0, 1'b0, 1'b1);
        drop();
        check("back_to_back_stalls", 32'(stalls), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // ---- multiply ----
`ifdef ALU_MUL_EN
        issue("mul", OP_MUL, 8'h93, 8'h02, 8'h26, 1'b1, 1'b0, 1'b1);
        drop();
        A  = 8'hFF;  // must not disturb the multiply in flight
        B  = 8'hFF;
        SL = OP_ADD;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check($sformatf("mul_busy_c%0d", i),     32'(busy),      32'd1);
            check($sformatf("mul_in_ready_c%0d", i), 32'(in_ready),  32'd0);
            check($sformatf("mul_no_out_c%0d", i),   32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("mul_done_valid", 32'(out_valid), 32'd1);
        check("mul_done_busy",  32'(busy),      32'd0);
        @(posedge clk);
        #1;
        issue("mul_0f", OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1);
        drop();
        repeat (W + 2) @(posedge clk);
        #1;
`else
        issue("mul_dis", OP_MUL, 8'h93, 8'h02, 8'h00, 1'b0, 1'b1, 1'b1);
        drop();
        @(negedge clk);
        check("mul_dis_valid", 32'(out_valid), 32'd1);
        check("mul_dis_busy",  32'(busy),      32'd0);
        @(posedge clk);
        #1;
`endif

        // ---- backpressure ----
        out_ready = 1'b0;
        issue("bp_add", OP_ADD, 8'h93, 8'h02, 8'h95, 1'b0, 1'b0, 1'b1);
        SL = OP_XOR;  // pending op waits behind the held result
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", i),    32'(out_valid), 32'd1);
            check($sformatf("bp_su_c%0d", i),       32'(Su),        32'h95);
            check($sformatf("bp_in_ready_c%0d", i), 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("bp_xor", OP_XOR, 8'h93, 8'h02, 8'h91, 1'b0, 1'b0, 1'b1);
        drop();
        @(negedge clk);
        check("bp_xor_valid", 32'(out_valid), 32'd1);
        check("bp_xor_su",    32'(Su),        32'h91);
        @(posedge clk);
        #1;

        // ---- reset in the middle of an operation ----
        out_ready = 1'b0;
`ifdef ALU_MUL_EN
        issue("rst_mul", OP_MUL, 8'h93, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
`else
        issue("rst_add", OP_ADD, 8'h93, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        drop();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (W + 2) @(negedge clk);
        check("post_reset_no_result", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        issue("post_rst_add", OP_ADD, 8'h93, 8'h02, 8'h95, 1'b0, 1'b0, 1'b1);
        drop();

        // ---- drain ----
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
